// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory with flush, preload port and
// optional bounds checking (IMEM_BOUNDS_CHECK_EN adds Imem2proc_err and NOOP returns).
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif
module imem_responder #(
   parameter int DEPTH = 1024,
   parameter int LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        proc2Imem_req,
   input  logic [31:0] proc2Imem_addr,
   output logic        Imem2proc_ready,
   output logic        Imem2proc_valid,
   output logic [31:0] Imem2proc_data,
   output logic [31:0] Imem2proc_addr,
   input  logic        flush,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
`ifdef IMEM_BOUNDS_CHECK_EN
   ,
   output logic        Imem2proc_err
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0] mem [DEPTH];
   logic [LAT-1:0] vld;
   logic [29:0] wa [LAT];
   logic accept, load_ok, fetch_oob, unused_bits;
   logic [31:0] rd_data;
   assign Imem2proc_ready = ~load_en;
   assign accept = proc2Imem_req && Imem2proc_ready;
   assign unused_bits = ^{load_addr, proc2Imem_addr[1:0]};
`ifdef IMEM_BOUNDS_CHECK_EN
   assign fetch_oob = wa[LAT-1] >= 30'(DEPTH);
   assign load_ok = load_addr[31:2] < 30'(DEPTH);
`else
   assign fetch_oob = 1'b0;
   assign load_ok = 1'b1;
`endif
   assign rd_data = fetch_oob ? `NOOP_INST : mem[wa[LAT-1][AW-1:0]];
   // Read happens at the output edge, so a same-edge load still returns the old word
   always_ff @(posedge clk) begin
      wa[0] <= proc2Imem_addr[31:2];
      for (int k = 1; k < LAT; k++) wa[k] <= wa[k-1];
      if (load_en && load_ok) mem[load_addr[AW+1:2]] <= load_data;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
         Imem2proc_valid <= 1'b0;
         Imem2proc_data <= '0;
         Imem2proc_addr <= '0;
`ifdef IMEM_BOUNDS_CHECK_EN
         Imem2proc_err <= 1'b0;
`endif
      end else begin
         vld[0] <= accept;
         for (int k = 1; k < LAT; k++) vld[k] <= vld[k-1] && !flush;
         Imem2proc_valid <= vld[LAT-1] && !flush;
         if (vld[LAT-1]) begin
            Imem2proc_data <= rd_data;
            Imem2proc_addr <= {wa[LAT-1], 2'b00};
         end
`ifdef IMEM_BOUNDS_CHECK_EN
         Imem2proc_err <= vld[LAT-1] && !flush && fetch_oob;
`endif
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and random fetch/flush/load traffic against a queue-based model.
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif
module tb_imem_responder;
   localparam int DEPTH = 1024;
   localparam int LAT = 2;
   localparam int AW = $clog2(DEPTH);
   logic clk = 0, rst = 0, req = 0, flush = 0, load_en = 0;
   logic [31:0] addr = 0, load_addr = 0, load_data = 0;
   logic ready, valid;
   logic [31:0] data, raddr;
`ifdef IMEM_BOUNDS_CHECK_EN
   logic err;
`endif
   typedef struct {int due; logic [29:0] wa;} ent_t;
   ent_t q[$];
   ent_t e;
   logic [31:0] mem_m [DEPTH];
   int t = 0, checks = 0, errors = 0;
   logic exp_v, exp_e;
   logic [31:0] exp_d, exp_a;

   imem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .proc2Imem_req(req), .proc2Imem_addr(addr),
      .Imem2proc_ready(ready), .Imem2proc_valid(valid),
      .Imem2proc_data(data), .Imem2proc_addr(raddr),
      .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef IMEM_BOUNDS_CHECK_EN
      , .Imem2proc_err(err)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit oob(input logic [29:0] w);
`ifdef IMEM_BOUNDS_CHECK_EN
      return w >= 30'(DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, update the model at posedge, compare at the next negedge
   task automatic step(input logic r, input logic [31:0] a, input logic f,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
      req = r; addr = a; flush = f; load_en = le; load_addr = la; load_data = ld;
      #1 chk("ready", {31'b0, ready}, {31'b0, !le});
      @(posedge clk);
      t++;
      if (f) q.delete();
      exp_v = 0; exp_e = 0;
      if (q.size() > 0 && q[0].due == t) begin
         e = q.pop_front();
         exp_v = 1;
         exp_e = oob(e.wa);
         exp_d = exp_e ? `NOOP_INST : mem_m[e.wa[AW-1:0]];
         exp_a = {e.wa, 2'b00};
      end
      if (r && !le) q.push_back('{t + LAT, a[31:2]});
      if (le && !oob(la[31:2])) mem_m[la[AW+1:2]] = ld;
      @(negedge clk);
      chk("valid", {31'b0, valid}, {31'b0, exp_v});
      if (exp_v) begin
         chk("data", data, exp_d);
         chk("addr", raddr, exp_a);
      end
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("err", {31'b0, err}, {31'b0, exp_e});
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1;
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_addr", raddr, 32'd0);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 32'(i * 4), i < 8 ? 32'(32'h100 + i) : $urandom);
      for (int i = 0; i < 8; i++) step(1, 32'(i * 4), 0, 0, 0, 0);
      idle(LAT + 1);
      // flush kills the in-flight fetch; a same-cycle request survives
      step(1, 32'h10, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      idle(LAT + 1);
      step(1, 32'h10, 0, 0, 0, 0);
      step(1, 32'h20, 1, 0, 0, 0);
      idle(LAT + 1);
      // load blocks a held request
      for (int i = 0; i < 3; i++) step(1, 32'h8, 0, 1, 32'h4, $urandom);
      step(1, 32'h8, 0, 0, 0, 0);
      idle(LAT + 1);
      // read-before-write on word 3
      step(1, 32'hC, 0, 0, 0, 0);
      idle(LAT - 1);
      step(0, 0, 0, 1, 32'hC, 32'hDEAD);
      step(1, 32'hC, 0, 0, 0, 0);
      idle(LAT + 1);
      step(1, 32'h1000, 0, 0, 0, 0);
      idle(LAT + 1);
      // reset with two requests in flight
      step(1, 32'h0, 0, 0, 0, 0);
      step(1, 32'h4, 0, 0, 0, 0);
      rst = 0; req = 0;
      #1;
      chk("midrst_valid", {31'b0, valid}, 32'd0);
      chk("midrst_data", data, 32'd0);
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
      idle(LAT + 3);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, la;
         a = $urandom_range(0, 9) == 0 ? 32'h1000 + 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, 63));
         la = $urandom_range(0, 9) == 0 ? 32'h1000 + 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, 63));
         step($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, la, $urandom);
      end
      idle(LAT + 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
